// File: rtl/vmul_pkg.sv
// -----------------------------------------------------------------------------
// vmul_pkg
// Shared constants, FSM state type and lane-slicing helper for the
// vector multiply issue block (vector_mult_issue / vmul_lane).
//   DATA_W         : lane width in bits
//   LANES          : lanes per operand vector (two beats of LANES_PER_BEAT)
//   LANES_PER_BEAT : lanes multiplied per issue group / written per beat
//   MUL_LAT        : issue-to-registered-product latency of vmul_lane
// -----------------------------------------------------------------------------
package vmul_pkg;

  localparam int DATA_W         = 32;
  localparam int LANES          = 8;
  localparam int LANES_PER_BEAT = 4;
  localparam int N_BEATS        = LANES / LANES_PER_BEAT;
  localparam int MUL_LAT        = 2;

  typedef enum logic [2:0] {
    IDLE,
    ISS0,
    ISS1,
    WAIT,
    WB0,
    GAP,
    WB1,
    DONE
  } state_e;

  // Bit offset of a lane inside a packed operand vector.
  function automatic int unsigned lane_lsb(input int unsigned lane,
                                           input int unsigned w);
    return lane * w;
  endfunction

endpackage

// File: rtl/vmul_lane.sv
// -----------------------------------------------------------------------------
// vmul_lane
// One 2-stage pipelined DATA_W x DATA_W multiplier lane with signed/unsigned
// select. The registered result is the low DATA_W bits of the full product,
// or, when VMUL_SATURATE_EN is defined, the product clamped to the DATA_W
// range of the selected signedness.
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset (valid pipeline only)
//   vld_i  : operands on a_i/b_i are to be multiplied
//   sgn_i  : 1 = treat a_i/b_i as signed
//   a_i    : operand A
//   b_i    : operand B
//   vld_o  : prod_o holds a new product (2 cycles after vld_i)
//   prod_o : truncated or saturated product
// Configuration macro: VMUL_SATURATE_EN
// -----------------------------------------------------------------------------
module vmul_lane
  import vmul_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_i,
  input  logic              sgn_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              vld_o,
  output logic [DATA_W-1:0] prod_o
);

  localparam int PW = 2 * DATA_W;

  logic                 vld_p0;
  logic                 vld_p1;
  logic                 sgn_p0;
  logic signed [PW-1:0] a_p0;
  logic signed [PW-1:0] b_p0;
  logic signed [PW-1:0] full_p0;
  logic [DATA_W-1:0]    prod_p1;

`ifdef VMUL_SATURATE_EN
  function automatic logic [DATA_W-1:0] sat_lane(input logic [PW-1:0] p,
                                                 input logic          sgn);
    logic [DATA_W-1:0] r;
    r = p[DATA_W-1:0];
    if (sgn) begin
      // In range only when bits [PW-1:DATA_W-1] are all copies of the sign.
      if (!p[PW-1] && (|p[PW-2:DATA_W-1])) begin
        r = {1'b0, {(DATA_W-1){1'b1}}};
      end else if (p[PW-1] && !(&p[PW-2:DATA_W-1])) begin
        r = {1'b1, {(DATA_W-1){1'b0}}};
      end
    end else if (|p[PW-1:DATA_W]) begin
      r = '1;
    end
    return r;
  endfunction
`else
  function automatic logic [DATA_W-1:0] trunc_lane(input logic [DATA_W-1:0] p);
    return p;
  endfunction

  // The upper product half and the mode only matter for the clamp.
  logic unused_prod_hi;
  assign unused_prod_hi = ^{full_p0[PW-1:DATA_W], sgn_p0};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= vld_i;
      vld_p1 <= vld_p0;
    end
  end

  // Stage p0: operands extended to the full product width. Multiplying the
  // extended values modulo 2^PW gives the exact product in either mode.
  always_ff @(posedge clk) begin
    sgn_p0 <= sgn_i;
    a_p0   <= {{DATA_W{sgn_i & a_i[DATA_W-1]}}, a_i};
    b_p0   <= {{DATA_W{sgn_i & b_i[DATA_W-1]}}, b_i};
  end

  assign full_p0 = a_p0 * b_p0;

  // Stage p1: registered lane result.
  always_ff @(posedge clk) begin
`ifdef VMUL_SATURATE_EN
    prod_p1 <= sat_lane(full_p0, sgn_p0);
`else
    prod_p1 <= trunc_lane(full_p0[DATA_W-1:0]);
`endif
  end

  assign vld_o  = vld_p1;
  assign prod_o = prod_p1;

endmodule

// File: rtl/vector_mult_issue.sv
// -----------------------------------------------------------------------------
// vector_mult_issue
// Latches two LANES x DATA_W operand vectors, multiplies them lane-wise on
// four pipelined vmul_lane instances in two issue groups, and delivers the
// eight products to the result bank as two 4-word write beats separated by a
// one-cycle we-low gap (the bank flips its half-select on each falling edge
// of we, so every operation leaves it back on half 0).
// Ports:
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset, aborts any operation
//   start       : request, sampled only in IDLE
//   signed_mode : 1 = signed lanes, latched with start
//   a_vec/b_vec : operand vectors, lane i at [DATA_W*i +: DATA_W]
//   busy        : high from the cycle after acceptance through the done cycle
//   done        : one-cycle completion pulse
//   we          : bank write enable
//   wd1..wd4    : bank write data, lanes 4g+0..4g+3 of group g
//   beat_sel    : group currently on wd1..wd4
// Configuration macro: VMUL_SATURATE_EN (clamp instead of wrap per lane)
// -----------------------------------------------------------------------------
module vector_mult_issue
  import vmul_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    signed_mode,
  input  logic [LANES*DATA_W-1:0] a_vec,
  input  logic [LANES*DATA_W-1:0] b_vec,
  output logic                    busy,
  output logic                    done,
  output logic                    we,
  output logic [DATA_W-1:0]       wd1,
  output logic [DATA_W-1:0]       wd2,
  output logic [DATA_W-1:0]       wd3,
  output logic [DATA_W-1:0]       wd4,
  output logic                    beat_sel
);

  localparam int LPB = LANES_PER_BEAT;

  state_e                  state_q;
  logic [LANES*DATA_W-1:0] a_q;
  logic [LANES*DATA_W-1:0] b_q;
  logic                    sgn_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    we_q;
  logic                    beat_q;
  logic [DATA_W-1:0]       wd_q   [LPB];
  logic [DATA_W-1:0]       res_q  [N_BEATS][LPB];

  logic                    iss_vld;
  logic                    iss_grp;
  logic                    grp_p0;
  logic                    grp_p1;
  logic [DATA_W-1:0]       iss_a     [LPB];
  logic [DATA_W-1:0]       iss_b     [LPB];
  logic [DATA_W-1:0]       lane_prod [LPB];
  logic [LPB-1:0]          lane_vld;

  assign iss_vld = (state_q == ISS0) || (state_q == ISS1);
  assign iss_grp = (state_q == ISS1);

  for (genvar i = 0; i < LPB; i++) begin : g_lane
    assign iss_a[i] = a_q[lane_lsb(iss_grp ? LPB + i : i, DATA_W) +: DATA_W];
    assign iss_b[i] = b_q[lane_lsb(iss_grp ? LPB + i : i, DATA_W) +: DATA_W];

    vmul_lane u_lane (
      .clk    (clk),
      .rst    (rst),
      .vld_i  (iss_vld),
      .sgn_i  (sgn_q),
      .a_i    (iss_a[i]),
      .b_i    (iss_b[i]),
      .vld_o  (lane_vld[i]),
      .prod_o (lane_prod[i])
    );
  end

  // Stage p0/p1: group tag travelling alongside the lane pipelines.
  always_ff @(posedge clk) begin
    if (rst) begin
      grp_p0 <= 1'b0;
      grp_p1 <= 1'b0;
    end else begin
      grp_p0 <= iss_grp;
      grp_p1 <= grp_p0;
    end
  end

  // Result buffer: one entry per issue group, filled as products emerge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int g = 0; g < N_BEATS; g++) begin
        for (int i = 0; i < LPB; i++) begin
          res_q[g][i] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < LPB; i++) begin
        if (lane_vld[i]) begin
          res_q[grp_p1][i] <= lane_prod[i];
        end
      end
    end
  end

  // Control FSM. Outputs are decoded from the current state and registered,
  // so every output trails its state by one cycle (WB0 state -> we at E0+4).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      beat_q  <= 1'b0;
      for (int i = 0; i < LPB; i++) begin
        wd_q[i] <= '0;
      end
    end else begin
      busy_q <= (state_q != IDLE);
      we_q   <= (state_q == WB0) || (state_q == WB1);
      done_q <= (state_q == DONE);
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a_vec;
            b_q     <= b_vec;
            sgn_q   <= signed_mode;
            state_q <= ISS0;
          end
        end
        ISS0: state_q <= ISS1;
        ISS1: state_q <= WAIT;
        WAIT: state_q <= WB0;
        WB0: begin
          beat_q <= 1'b0;
          for (int i = 0; i < LPB; i++) begin
            wd_q[i] <= res_q[0][i];
          end
          state_q <= GAP;
        end
        // wd holds group 0 while we drops, giving the bank its falling edge.
        GAP: state_q <= WB1;
        WB1: begin
          beat_q <= 1'b1;
          for (int i = 0; i < LPB; i++) begin
            wd_q[i] <= res_q[1][i];
          end
          state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign we       = we_q;
  assign beat_sel = beat_q;
  assign wd1      = wd_q[0];
  assign wd2      = wd_q[1];
  assign wd3      = wd_q[2];
  assign wd4      = wd_q[3];

endmodule
